wb_xbus: RTL

WB_XBUS -- requirements
Module: wb_xbus

---
 rtl/wb_xbus.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_xbus.sv
// -----------------------------------------------------------------------------
// wb_xbus : shared-bus Wishbone crossbar, NUM_M masters onto NUM_S slaves.
//
// One master at a time owns the bus (round-robin, no preemption while its cyc
// is held). The owner's address/data/select/we are broadcast to all slaves,
// and cyc/stb go only to the slave whose base matches the top DEC_W address
// bits. The selected slave's data and terminations return combinationally to
// the owner. An owner strobe that hits no slave gets a one-cycle error pulse.
//
// Optional feature: define WB_XBUS_TIMEOUT_EN to build a bus watchdog that
// errors a strobe left unterminated for TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i/m_we_i    packed per-master request fields
//   m_cyc_i/m_stb_i                   per-master cycle / strobe
//   m_dat_o                           shared read data (0 when nothing selected)
//   m_ack_o/m_err_o/m_rty_o           per-master terminations (owner only)
//   s_adr_o/s_dat_o/s_sel_o/s_we_o    owner request broadcast to slaves
//   s_cyc_o/s_stb_o                   per-slave cycle / strobe (selected only)
//   s_dat_i/s_ack_i/s_err_i/s_rty_i   packed per-slave responses
// -----------------------------------------------------------------------------
module wb_xbus #(
    parameter int                     NUM_M   = 2,
    parameter int                     NUM_S   = 4,
    parameter int                     DEC_W   = 4,
    parameter logic [NUM_S*DEC_W-1:0] S_BASE  = {4'hF, 4'h5, 4'h4, 4'h0},
    parameter int                     TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_M*32-1:0]   m_adr_i,
    input  logic [NUM_M*32-1:0]   m_dat_i,
    input  logic [NUM_M*4-1:0]    m_sel_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    output logic [31:0]           m_dat_o,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic [NUM_M-1:0]      m_rty_o,
    output logic [31:0]           s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_we_o,
    output logic [NUM_S-1:0]      s_cyc_o,
    output logic [NUM_S-1:0]      s_stb_o,
    input  logic [NUM_S*32-1:0]   s_dat_i,
    input  logic [NUM_S-1:0]      s_ack_i,
    input  logic [NUM_S-1:0]      s_err_i,
    input  logic [NUM_S-1:0]      s_rty_i
);

    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    // Round-robin pointer; starts at NUM_M-1 so the first search begins at 0.
    logic [GW-1:0]   last_q, last_d;
    logic            gnt_vld;

    logic            req_found;
    logic [GW-1:0]   req_idx;
    logic [GW-1:0]   cand;

    logic [31:0]     o_adr, o_dat;
    logic [3:0]      o_sel;
    logic            o_we, o_cyc, o_stb;

    logic            hit;
    logic [SW-1:0]   sel;
    logic [31:0]     sel_dat;
    logic            sel_ack, sel_err, sel_rty;

    logic            derr_q;
    logic            to_hit;

    assign gnt_vld = (state_q == OWNED);

    // Next requester after the last owner, wrapping NUM_M-1 -> 0.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = GW'((int'(last_q) + i) % NUM_M);
            if (!req_found && m_cyc_i[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = OWNED;
                    gnt_d   = req_idx;
                    last_d  = req_idx;
                end
            end
            OWNED: begin
                // Owner released: hand over on this same edge, or go idle.
                if (!m_cyc_i[gnt_q]) begin
                    if (req_found) begin
                        gnt_d  = req_idx;
                        last_d = req_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Owner request mux.
    always_comb begin
        o_adr = '0;
        o_dat = '0;
        o_sel = '0;
        o_we  = 1'b0;
        o_cyc = 1'b0;
        o_stb = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_vld && (GW'(i) == gnt_q)) begin
                o_adr = m_adr_i[i*32 +: 32];
                o_dat = m_dat_i[i*32 +: 32];
                o_sel = m_sel_i[i*4 +: 4];
                o_we  = m_we_i[i];
                o_cyc = m_cyc_i[i];
                o_stb = m_stb_i[i];
            end
        end
    end

    // Address decode; descending scan so the lowest matching slave wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int j = NUM_S - 1; j >= 0; j--) begin
            if (gnt_vld && (o_adr[31 -: DEC_W] == S_BASE[j*DEC_W +: DEC_W])) begin
                hit = 1'b1;
                sel = SW'(j);
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        for (int j = 0; j < NUM_S; j++) begin
            if (hit && (SW'(j) == sel)) begin
                sel_dat = s_dat_i[j*32 +: 32];
                sel_ack = s_ack_i[j] & o_cyc;
                sel_err = s_err_i[j] & o_cyc;
                sel_rty = s_rty_i[j] & o_cyc;
            end
        end
    end

    // Decode-error pulse; gating on !derr_q forces a low cycle between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            derr_q <= 1'b0;
        end else begin
            derr_q <= gnt_vld && o_cyc && o_stb && !hit && !derr_q;
        end
    end

`ifdef WB_XBUS_TIMEOUT_EN
    logic [15:0] wd_cnt_q;
    logic        stalled;

    assign stalled = o_cyc && o_stb && hit && !(sel_ack || sel_err || sel_rty);
    // Fires in the TIMEOUT-th consecutive stalled cycle.
    assign to_hit  = stalled && (wd_cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else if (!stalled || to_hit) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign s_adr_o = o_adr;
    assign s_dat_o = o_dat;
    assign s_sel_o = o_sel;
    assign s_we_o  = o_we;
    assign m_dat_o = hit ? sel_dat : 32'd0;

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (hit && (SW'(j) == sel)) begin
                s_cyc_o[j] = o_cyc;
                s_stb_o[j] = o_stb && !to_hit;
            end
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_vld && (GW'(i) == gnt_q)) begin
                m_ack_o[i] = sel_ack;
                m_err_o[i] = sel_err || derr_q || to_hit;
                m_rty_o[i] = sel_rty;
            end
        end
    end

endmodule
